// File: rtl/definitions_pkg.sv
// Shared constants and types for the Gaussian smoothing stage.
// Contents:
//   IMAGE_WIDTH / IMAGE_HEIGHT - default frame geometry in pixels
//   GAUSS_SHIFT                - log2 of the kernel weight total (16)
//   GAUSS_ROUND                - half-LSB offset used for round-to-nearest
//   gaussian_kernel_3          - 3x3 weights, entry [r*3+c]
//   gauss_state_t              - frame sequencing states
package definitions_pkg;

  localparam int IMAGE_WIDTH  = 512;
  localparam int IMAGE_HEIGHT = 512;
  localparam int GAUSS_SHIFT  = 4;
  localparam int GAUSS_ROUND  = 1 << (GAUSS_SHIFT - 1);

  // Binomial kernel {1,2,1; 2,4,2; 1,2,1}; symmetric, so index order is moot.
  localparam logic [8:0][2:0] gaussian_kernel_3 = {
    3'd1, 3'd2, 3'd1,
    3'd2, 3'd4, 3'd2,
    3'd1, 3'd2, 3'd1
  };

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } gauss_state_t;

endpackage

// File: rtl/line_buffer.sv
// One row store for the 3x3 window.
// Ports:
//   clk        - clock
//   en_i       - perform the read/write this cycle
//   addr_i     - column address, shared by read and write
//   wr_data_i  - pixel written at addr_i when en_i is high
//   rd_data_o  - contents of addr_i before this cycle's write
// Contents are deliberately not reset; a new frame rewrites every entry
// before it is read.
module line_buffer #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 8,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Asynchronous read yields the previous row's pixel for this column.
  assign rd_data_o = mem_q[addr_i];

  // Overwrite the column with the newer row's pixel.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/gaussian_filter.sv
// 3x3 Gaussian smoothing of a raster greyscale stream, valid mode only
// (output frame is (IMAGE_WIDTH-2) x (IMAGE_HEIGHT-2)).
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   s_valid/s_ready     - input pixel handshake, s_data pixel
//   m_valid/m_ready     - output pixel handshake, m_data pixel
//   frame_done          - high during the last output handshake of a frame
// Build option: define GAUSS_ROUND_EN for (sum+8)>>4 rounding; otherwise
// the weighted sum is truncated (sum>>4).
module gaussian_filter #(
  parameter int IMAGE_WIDTH  = definitions_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = definitions_pkg::IMAGE_HEIGHT,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              frame_done
);
  import definitions_pkg::*;

  localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int SUM_W = DATA_W + GAUSS_SHIFT;

  gauss_state_t      state_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              s_ready_q;
  logic              stall_s, accept_s, col_last_s, row_last_s, out_pos_s;
  logic              frame_done_s;
  logic [DATA_W-1:0] lb0_rd_s, lb1_rd_s;
  logic [DATA_W-1:0] win_q [3][2];
  logic [DATA_W-1:0] tap_s [3][3];
  logic [SUM_W-1:0]  sum_d, sum_q, rounded_s;
  logic              sum_v_q, sum_last_q;
  logic [DATA_W-1:0] scaled_s, m_data_q;
  logic              m_valid_q, m_last_q;

  // A held output freezes every stage, so nothing can be dropped or doubled.
  assign stall_s      = m_valid_q & ~m_ready;
  assign s_ready      = s_ready_q & ~stall_s;
  assign accept_s     = s_valid & s_ready;
  assign col_last_s   = (col_q == COL_W'(IMAGE_WIDTH - 1));
  assign row_last_s   = (row_q == ROW_W'(IMAGE_HEIGHT - 1));
  assign out_pos_s    = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign frame_done_s = m_valid_q & m_ready & m_last_q;

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign frame_done = frame_done_s;

  // lb0 holds row r-1, lb1 holds row r-2; lb0's old entry cascades into lb1.
  line_buffer #(.DEPTH(IMAGE_WIDTH), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_lb0 (
    .clk(clk), .en_i(accept_s), .addr_i(col_q), .wr_data_i(s_data), .rd_data_o(lb0_rd_s)
  );
  line_buffer #(.DEPTH(IMAGE_WIDTH), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_lb1 (
    .clk(clk), .en_i(accept_s), .addr_i(col_q), .wr_data_i(lb0_rd_s), .rd_data_o(lb1_rd_s)
  );

  // Assemble the 3x3 taps (two stored columns + incoming column) and weight them.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 2; j++) begin
        tap_s[i][j] = win_q[i][j];
      end
    end
    tap_s[0][2] = lb1_rd_s;
    tap_s[1][2] = lb0_rd_s;
    tap_s[2][2] = s_data;
    sum_d = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        sum_d = sum_d + SUM_W'(tap_s[i][j]) * SUM_W'(gaussian_kernel_3[i*3+j]);
      end
    end
  end

  // Normalise the registered sum by the kernel total; max sum plus offset fits SUM_W.
  always_comb begin
`ifdef GAUSS_ROUND_EN
    rounded_s = sum_q + SUM_W'(GAUSS_ROUND);
`else
    rounded_s = sum_q;
`endif
    scaled_s = DATA_W'(rounded_s >> GAUSS_SHIFT);
  end

  // Shift the window one column left on every accepted pixel.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= tap_s[i][2];
      end
    end
  end

  // Frame sequencer: raster counters, state and the registered input enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      col_q     <= '0;
      row_q     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      if (accept_s) begin
        if (col_last_s) begin
          col_q <= '0;
          row_q <= row_last_s ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      case (state_q)
        FILL: begin
          s_ready_q <= 1'b1;
          if (accept_s && (row_q == ROW_W'(2)) && (col_q == '0)) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (accept_s && col_last_s && row_last_s) begin
            state_q   <= FLUSH;
            s_ready_q <= 1'b0;
          end else begin
            s_ready_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (frame_done_s) begin
            state_q   <= FILL;
            col_q     <= '0;
            row_q     <= '0;
            s_ready_q <= 1'b1;
          end else begin
            s_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= FILL;
          col_q     <= '0;
          row_q     <= '0;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage output pipe: weighted sum, then normalised pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q      <= '0;
      sum_v_q    <= 1'b0;
      sum_last_q <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
    end else if (!stall_s) begin
      sum_v_q    <= accept_s & out_pos_s;
      sum_last_q <= accept_s & col_last_s & row_last_s;
      if (accept_s) begin
        sum_q <= sum_d;
      end
      m_valid_q <= sum_v_q;
      m_last_q  <= sum_last_q;
      if (sum_v_q) begin
        m_data_q <= scaled_s;
      end
    end
  end

endmodule

// File: tb/tb_gaussian_filter.sv
// Scoreboard bench for gaussian_filter with an 8x6 frame.
// Expected pixels come from a direct convolution of the stimulus image and
// are queued when a frame is issued; a negedge monitor pops and compares.
module tb_gaussian_filter;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b1;
  logic          s_ready, m_valid, frame_done;
  logic [DW-1:0] s_data = '0;
  logic [DW-1:0] m_data;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  int         img[H][W];
  int         ready_low = 0;
  bit         ready_rand = 1'b0;
  int         acc_cnt = 0;
  int         out_idx = 0;
  int         fd_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  gaussian_filter #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Direct 3x3 convolution of img; queues the first 'limit' output pixels.
  task automatic push_expected(input int limit);
    int n = 0;
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        int s;
        int o;
        s = img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]
          + 2*img[r][c-1] + 4*img[r][c]   + 2*img[r][c+1]
          + img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1];
`ifdef GAUSS_ROUND_EN
        o = (s + 8) / 16;
`else
        o = s / 16;
`endif
        if (n < limit) exp_q.push_back({(r == H-2 && c == W-2) ? 1'b1 : 1'b0, o[7:0]});
        n++;
      end
    end
  endtask

  // Send the first n_pix raster pixels of img; valid_pct controls s_valid gaps.
  task automatic drive_frame(input int n_pix, input int valid_pct, input int stall_idx);
    for (int k = 0; k < n_pix; k++) begin
      bit got;
      int waited;
      if (k == stall_idx) ready_low = 10;
      while ($urandom_range(99) >= valid_pct) begin
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = DW'(img[k / W][k % W]);
      got = 1'b0;
      waited = 0;
      while (!got && waited < 2000) begin
        @(negedge clk);
        got = s_ready;
        @(posedge clk); #1;
        waited++;
      end
      if (!got) begin
        chk("s_ready_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    if (n_pix == W * H) begin
      @(negedge clk);
      chk("flush_s_ready", int'(s_ready), 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", (n < 500) ? 1 : 0, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Downstream ready pattern: forced-low window, random, or always ready.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_low > 0) begin
        m_ready = 1'b0;
        ready_low--;
      end else if (ready_rand) begin
        m_ready = ($urandom_range(99) < 65);
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pop, frame_done, stall hold and output-vs-input ordering.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_cnt    = 0;
        out_idx    = 0;
        prev_stall = 1'b0;
      end else begin
        bit         hs;
        bit         exp_fd;
        logic [8:0] e;
        hs = m_valid && m_ready;
        exp_fd = 1'b0;
        if (prev_stall) begin
          chk("stall_hold_valid", int'(m_valid), 1);
          chk("stall_hold_data", int'(m_data), int'(prev_data));
        end
        if (m_valid && !m_ready) chk("stall_s_ready", int'(s_ready), 0);
        if (hs) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", int'(m_data), -1);
          end else begin
            int r;
            int c;
            e = exp_q.pop_front();
            chk("m_data", int'(m_data), int'(e[7:0]));
            exp_fd = e[8];
            r = 1 + out_idx / (W - 2);
            c = 1 + out_idx % (W - 2);
            chk("output_after_input", (acc_cnt >= (r + 1) * W + c + 2) ? 1 : 0, 1);
            out_idx++;
          end
        end
        chk("frame_done", int'(frame_done), int'(exp_fd));
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (frame_done) begin
          fd_cnt++;
          acc_cnt = 0;
          out_idx = 0;
        end
        if (s_valid && s_ready) acc_cnt++;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("s_ready_after_rst", int'(s_ready), 1);
    @(posedge clk); #1;

    // Constant frame.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 100;
    push_expected(24);
    drive_frame(W * H, 100, -1);
    wait_drain();
    chk("fd_count_const", fd_cnt, 1);

    // Single bright pixel at (3,3).
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 0;
    img[3][3] = 255;
    push_expected(24);
    drive_frame(W * H, 100, -1);
    wait_drain();

    // Ramp with a 10-cycle downstream stall in the middle of RUN.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = c * 10 + r;
    push_expected(24);
    drive_frame(W * H, 100, 3 * W + 4);
    wait_drain();

    // Abandon a frame during row 3, then a constant-50 frame.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(255));
    push_expected(8);
    drive_frame(3 * W + 4, 100, -1);
    repeat (6) begin @(posedge clk); #1; end
    chk("abort_outputs_seen", exp_q.size(), 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_s_ready", int'(s_ready), 0);
    chk("midrst_m_valid", int'(m_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 50;
    push_expected(24);
    drive_frame(W * H, 100, -1);
    wait_drain();

    // Two back-to-back random frames under random valid/ready.
    ready_rand = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(255));
      push_expected(24);
      drive_frame(W * H, 60, -1);
    end
    ready_rand = 1'b0;
    wait_drain();

    chk("fd_count_total", fd_cnt, 6);
    chk("leftover_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
